nv_nvdla_nocif_wr_rsp_tracker: RTL and testbench
================================================

// Module: nv_nvdla_nocif_wr_rsp_tracker
// PURPOSE
//  Parametrised write-response tracker for the NOC interface write path (CVIF/MCIF class).
//  Records every issued AXI write request in a per-client completion queue.
//  Matches returning AXI B responses by ID and pulses the per-client write-complete outputs.
//  Returns outstanding-beat credits to the ingress side.
//  Adds capabilities the fixed 5-client path lacks: N clients, configurable queue depth,
//  beat-based outstanding limit, and sticky detection of unexpected B IDs.
// PARAMETERS
//  NUM_CLIENTS  5   number of write clients; AXI ID low bits = client index
//  CQ_DEPTH     16  per-client completion-queue entries (power of 2, >=2)
//  LEN_W        2   request length field width; beats = len+1
//  ID_W         8   AXI B ID width
//  OS_W         8   outstanding-limit register width
//  (derived)    CL_W = clog2(NUM_CLIENTS)
// PORTS
//  nvdla_core_clk         in   1            core clock
//  nvdla_core_rst         in   1            async reset, active-high
//  issue_vld              in   1            ingress has a request accepted onto AW
//  issue_rdy              out  1            tracker can accept that request
//  issue_client           in   CL_W         client index of request
//  issue_len              in   LEN_W        beats-1
//  issue_ack              in   1            client wants a completion pulse
//  reg2dp_wr_os_cnt       in   OS_W         max outstanding beats minus 1
//  noc2cvif_axi_b_bvalid  in   1            B response valid
//  noc2cvif_axi_b_bready  out  1            B response ready
//  noc2cvif_axi_b_bid     in   ID_W         B response ID
//  wr_rsp_complete        out  NUM_CLIENTS  one-cycle completion pulse per client
//  os_release_vld         out  1            credit-return pulse
//  os_release_len         out  LEN_W        beats-1 being returned
//  os_cnt_cur             out  OS_W+1       current outstanding beats
//  err_unexp_bid          out  1            sticky: B with no matching entry
//  err_clr                in   1            clears err_unexp_bid
// BEHAVIOUR
//  Reset (async, rst=1): all queue pointers 0, os_cnt 0, err 0; all outputs 0 incl. bready.
//   - bready rises the first clk edge after rst deasserts and then stays 1.
//  Issue accept = issue_vld & issue_rdy.
//   - issue_rdy = ~rst_q & ~full[issue_client]
//                 & (os_cnt + issue_len + 1 <= reg2dp_wr_os_cnt + 1); arithmetic in OS_W+2 bits.
//   - issue_client >= NUM_CLIENTS -> issue_rdy=0.
//   - issue_rdy depends only on registered state and the issue_* inputs.
//   - No combinational path from bvalid to issue_rdy.
//   - On accept: push {issue_ack, issue_len} into queue[issue_client]; os_cnt += issue_len+1.
//  Queues: circular buffers with CLOG2(CQ_DEPTH)+1-bit pointers.
//   - full when ptrs differ only in the wrap bit; empty when equal.
//  B accept = bvalid & bready.
//   - Match when bid[ID_W-1:CL_W]==0, bid[CL_W-1:0] < NUM_CLIENTS, and that queue is non-empty
//     (emptiness sampled before same-cycle push).
//   - On match: pop head; os_cnt -= head.len+1.
//   - Same edge registers os_release_vld=1, os_release_len=head.len, and
//     wr_rsp_complete[client]=head.ack.
//   - These outputs are visible the cycle after the B handshake (latency 1) and clear after one
//     cycle unless another match occurs.
//   - No match: no pop, no credit, no pulse; err_unexp_bid<=1.
//  Simultaneous events:
//   - Issue and release in the same cycle: os_cnt <= os_cnt + (len_in+1) - (len_out+1).
//   - Push and pop on the same queue: both happen; occupancy is unchanged.
//   - err_clr together with a new error: set wins.
//  os_cnt never exceeds reg2dp_wr_os_cnt+1.
//   - Lowering the register while traffic is in flight blocks issue until os_cnt drains below
//     the new limit; no underflow or overflow.
//  Reset mid-operation: queues flushed, pending completions and credits discarded.
//   - Late B responses after reset flag err_unexp_bid.
// TESTING
//  1. Reset release: bready=0 in reset, 1 one cycle later; os_cnt_cur=0; complete=0.
//  2. Single flow: issue client2 len=3 ack=1 -> os_cnt_cur=4.
//     B bid=2 -> next cycle complete[2]=1 for 1 cycle, os_release_len=3, os_cnt_cur=0.
//  3. OS limit: reg=7; issue client0 len=3 x2 -> os_cnt_cur=8 -> issue_rdy=0 for len=0.
//     B bid=0 -> issue_rdy=1 next cycle.
//  4. Queue full: CQ_DEPTH=16; 16 issues client1 len=0 (reg=255) -> issue_rdy=0 for client1,
//     1 for client3.
//     Simultaneous B bid=1 and issue client1 -> occupancy stays 16.
//  5. In-order per client: issue c4 ack=0 then c4 ack=1; B bid=4 twice.
//     -> first response: no complete pulse, release only; second response: complete[4]=1.
//  6. Error: B bid=9 (NUM_CLIENTS=5), or bid=0 with empty queue -> err_unexp_bid=1, os_cnt
//     unchanged.
//     err_clr coincident with new bad bid -> stays 1; err_clr alone -> 0.

Source files
------------

// File: rtl/nv_nvdla_nocif_wr_rsp_tracker.sv
// nv_nvdla_nocif_wr_rsp_tracker: per-client write completion queues matched against AXI B
// responses by ID, with beat-based outstanding credit tracking and sticky unexpected-ID error.
module nv_nvdla_nocif_wr_rsp_tracker #(
   parameter int NUM_CLIENTS = 5,
   parameter int CQ_DEPTH    = 16,
   parameter int LEN_W       = 2,
   parameter int ID_W        = 8,
   parameter int OS_W        = 8,
   localparam int CL_W       = NUM_CLIENTS > 1 ? $clog2(NUM_CLIENTS) : 1
) (
   input  logic                   nvdla_core_clk,
   input  logic                   nvdla_core_rst,
   input  logic                   issue_vld,
   output logic                   issue_rdy,
   input  logic [CL_W-1:0]        issue_client,
   input  logic [LEN_W-1:0]       issue_len,
   input  logic                   issue_ack,
   input  logic [OS_W-1:0]        reg2dp_wr_os_cnt,
   input  logic                   noc2cvif_axi_b_bvalid,
   output logic                   noc2cvif_axi_b_bready,
   input  logic [ID_W-1:0]        noc2cvif_axi_b_bid,
   output logic [NUM_CLIENTS-1:0] wr_rsp_complete,
   output logic                   os_release_vld,
   output logic [LEN_W-1:0]       os_release_len,
   output logic [OS_W:0]          os_cnt_cur,
   output logic                   err_unexp_bid,
   input  logic                   err_clr
);
   localparam int AW = $clog2(CQ_DEPTH);
   localparam int NP = 1 << CL_W;
   localparam int SW = OS_W + 2;
   logic [LEN_W:0] mem [NUM_CLIENTS][CQ_DEPTH];
   logic [AW:0] wp [NUM_CLIENTS];
   logic [AW:0] rp [NUM_CLIENTS];
   logic [NP-1:0] full_v, nemp_v;
   logic [CL_W-1:0] b_cl, b_ci;
   logic [LEN_W:0] head;
   logic push, b_acc, match;
   logic [SW-1:0] os_add, os_sub, os_nxt;
   // Client slots beyond NUM_CLIENTS read as full and empty so they never accept or match.
   always_comb begin
      full_v = '1;
      nemp_v = '0;
      for (int c = 0; c < NUM_CLIENTS; c++) begin
         full_v[c] = (wp[c] ^ rp[c]) == {1'b1, {AW{1'b0}}};
         nemp_v[c] = wp[c] != rp[c];
      end
      issue_rdy = noc2cvif_axi_b_bready & ~full_v[issue_client]
                  & (SW'(os_cnt_cur) + SW'(issue_len) + SW'(1) <= SW'(reg2dp_wr_os_cnt) + SW'(1));
      push = issue_vld & issue_rdy;
      b_cl = noc2cvif_axi_b_bid[CL_W-1:0];
      b_ci = (32'(b_cl) < NUM_CLIENTS) ? b_cl : '0;
      head = mem[b_ci][rp[b_ci][AW-1:0]];
      b_acc = noc2cvif_axi_b_bvalid & noc2cvif_axi_b_bready;
      match = b_acc & ((noc2cvif_axi_b_bid >> CL_W) == '0) & nemp_v[b_cl];
      os_add = push ? SW'(issue_len) + SW'(1) : '0;
      os_sub = match ? SW'(head[LEN_W-1:0]) + SW'(1) : '0;
      os_nxt = SW'(os_cnt_cur) + os_add - os_sub;
   end
   always_ff @(posedge nvdla_core_clk) begin
      if (push) mem[issue_client][wp[issue_client][AW-1:0]] <= {issue_ack, issue_len};
   end
   always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
      if (nvdla_core_rst) begin
         noc2cvif_axi_b_bready <= 1'b0;
         os_cnt_cur <= '0;
         err_unexp_bid <= 1'b0;
         os_release_vld <= 1'b0;
         os_release_len <= '0;
         wr_rsp_complete <= '0;
         for (int c = 0; c < NUM_CLIENTS; c++) begin
            wp[c] <= '0;
            rp[c] <= '0;
         end
      end else begin
         noc2cvif_axi_b_bready <= 1'b1;
         os_cnt_cur <= os_nxt[OS_W:0];
         if (push) wp[issue_client] <= wp[issue_client] + 1'b1;
         if (match) rp[b_ci] <= rp[b_ci] + 1'b1;
         os_release_vld <= match;
         os_release_len <= match ? head[LEN_W-1:0] : '0;
         wr_rsp_complete <= (match & head[LEN_W]) ? NUM_CLIENTS'(1) << b_ci : '0;
         err_unexp_bid <= (b_acc & ~match) | (err_unexp_bid & ~err_clr);
      end
   end
endmodule

// File: tb/tb_nv_nvdla_nocif_wr_rsp_tracker.sv
// tb_nv_nvdla_nocif_wr_rsp_tracker: directed scenarios plus random traffic checked against a
// queue-based reference model of the tracker.
module tb_nv_nvdla_nocif_wr_rsp_tracker;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic issue_vld = 1'b0, issue_ack = 1'b0, bvalid = 1'b0, err_clr = 1'b0;
   logic [2:0] issue_client = '0;
   logic [1:0] issue_len = '0;
   logic [7:0] os_reg = 8'd255, bid = '0;
   logic issue_rdy, bready, rel_vld, err;
   logic [4:0] complete;
   logic [1:0] rel_len;
   logic [8:0] os_cnt;
   int checks = 0, fails = 0;
   int ql [5][$];
   bit qa [5][$];
   int os_m = 0;
   bit err_m = 0, bready_m = 0;

   always #5 clk = ~clk;

   nv_nvdla_nocif_wr_rsp_tracker dut (
      .nvdla_core_clk(clk), .nvdla_core_rst(rst),
      .issue_vld(issue_vld), .issue_rdy(issue_rdy), .issue_client(issue_client),
      .issue_len(issue_len), .issue_ack(issue_ack), .reg2dp_wr_os_cnt(os_reg),
      .noc2cvif_axi_b_bvalid(bvalid), .noc2cvif_axi_b_bready(bready),
      .noc2cvif_axi_b_bid(bid), .wr_rsp_complete(complete),
      .os_release_vld(rel_vld), .os_release_len(rel_len), .os_cnt_cur(os_cnt),
      .err_unexp_bid(err), .err_clr(err_clr)
   );

   task automatic chk(input string tag, input longint got, input longint exp);
      checks++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #1;
      chk("rst_bready", bready, 0);
      chk("rst_os", os_cnt, 0);
      chk("rst_complete", complete, 0);
      chk("rst_rel_vld", rel_vld, 0);
      chk("rst_err", err, 0);
      chk("rst_rdy", issue_rdy, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      for (int c = 0; c < 5; c++) begin
         ql[c].delete();
         qa[c].delete();
      end
      os_m = 0;
      err_m = 0;
      bready_m = 0;
   endtask

   task automatic step(input bit v, input int cl, input int ln, input bit ak,
                       input bit bv, input int b, input bit clr);
      bit rdy_m, hit, push;
      int exp_len, exp_comp;
      issue_vld = v;
      issue_client = cl[2:0];
      issue_len = ln[1:0];
      issue_ack = ak;
      bvalid = bv;
      bid = b[7:0];
      err_clr = clr;
      @(negedge clk);
      rdy_m = bready_m && (cl < 5 ? (ql[cl].size() < 16) : 0) && (os_m + ln + 1 <= int'(os_reg) + 1);
      chk("issue_rdy", issue_rdy, rdy_m);
      chk("bready", bready, bready_m);
      hit = bv && bready_m && (b < 5 ? (ql[b].size() > 0) : 0);
      push = v && rdy_m;
      exp_len = 0;
      exp_comp = 0;
      if (hit) begin
         exp_len = ql[b].pop_front();
         exp_comp = qa[b].pop_front() ? (1 << b) : 0;
         os_m -= exp_len + 1;
      end
      if (push) begin
         ql[cl].push_back(ln);
         qa[cl].push_back(ak);
         os_m += ln + 1;
      end
      if (bv && bready_m && !hit) err_m = 1;
      else if (clr) err_m = 0;
      bready_m = 1;
      @(posedge clk);
      #1;
      chk("rel_vld", rel_vld, hit);
      if (hit) chk("rel_len", rel_len, exp_len);
      chk("complete", complete, exp_comp);
      chk("os_cnt", os_cnt, os_m);
      chk("err", err, err_m);
   endtask

   task automatic idle();
      step(0, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      do_reset();
      idle();
      // single flow
      step(1, 2, 3, 1, 0, 0, 0);
      step(0, 0, 0, 0, 1, 2, 0);
      idle();
      // outstanding limit
      os_reg = 8'd7;
      step(1, 0, 3, 0, 0, 0, 0);
      step(1, 0, 3, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 1, 0, 0);
      step(1, 0, 0, 0, 0, 0, 0);
      // queue full
      os_reg = 8'd255;
      repeat (16) step(1, 1, 0, 1, 0, 0, 0);
      step(1, 1, 0, 0, 0, 0, 0);
      step(1, 3, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 1, 1, 0);
      step(1, 1, 0, 1, 1, 1, 0);
      step(1, 1, 0, 1, 0, 0, 0);
      step(1, 1, 0, 1, 0, 0, 0);
      // per-client ordering
      step(1, 4, 1, 0, 0, 0, 0);
      step(1, 4, 2, 1, 0, 0, 0);
      step(0, 0, 0, 0, 1, 4, 0);
      step(0, 0, 0, 0, 1, 4, 0);
      // errors
      step(0, 0, 0, 0, 1, 9, 0);
      step(0, 0, 0, 0, 0, 0, 1);
      repeat (2) step(0, 0, 0, 0, 1, 0, 0);
      step(0, 0, 0, 0, 1, 0, 0);
      step(0, 0, 0, 0, 1, 200, 1);
      step(0, 0, 0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 1, 2, 0);
      step(0, 0, 0, 0, 0, 0, 1);
      // random traffic with a reset in the middle
      for (int i = 0; i < 3000; i++) begin
         if (i == 1500) begin
            do_reset();
            step(0, 0, 0, 0, 1, 3, 0);
         end
         if ($urandom_range(0, 99) == 0) os_reg = 8'($urandom_range(0, 20));
         step($urandom_range(0, 2) != 0, $urandom_range(0, 5), $urandom_range(0, 3),
              1'($urandom), $urandom_range(0, 2) != 0,
              $urandom_range(0, 19) == 0 ? $urandom_range(0, 255) : $urandom_range(0, 4),
              $urandom_range(0, 9) == 0);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end
endmodule
